// File: rtl/alu_serial_engine_if.sv
// Request/result bus for alu_serial_engine: one request channel (op/a/b) and one result channel (y/flags).
// A channel transfers on a rising clk edge where valid and ready are both 1. Once valid is raised,
// the payload holds stable and valid stays high until that transfer. Ready may be driven independently of valid.
interface alu_serial_engine_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry_out;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, carry_out, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, carry_out, zero
  );
endinterface

// File: rtl/alu_serial_engine.sv
// Bit-serial ALU: one result bit per cycle, LSB first, through an IDLE/RUN/DONE FSM.
// Optional flag outputs (carry_out, zero) are built only when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_engine #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_serial_engine_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;
  logic [IW-1:0]    idx;
  logic             carry_q;

  logic             bit_res;
  logic             carry_nxt;
  logic             b_eff;
  logic [WIDTH-1:0] res_nxt;

  // Operands are shifted right each RUN cycle, so the active bit is always at position 0.
  always_comb begin
    bit_res   = 1'b0;
    carry_nxt = 1'b0;
    b_eff     = b_q[0] ^ (op_q == OP_SUB);
    case (op_q)
      OP_ADD, OP_SUB: begin
        bit_res   = a_q[0] ^ b_eff ^ carry_q;
        carry_nxt = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);
      end
      OP_AND:  bit_res = a_q[0] & b_q[0];
      OP_OR:   bit_res = a_q[0] | b_q[0];
      OP_XOR:  bit_res = a_q[0] ^ b_q[0];
      OP_NAND: bit_res = ~(a_q[0] & b_q[0]);
      OP_NOR:  bit_res = ~(a_q[0] | b_q[0]);
      default: bit_res = ~(a_q[0] ^ b_q[0]);
    endcase
    res_nxt = {bit_res, res_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx         <= '0;
      carry_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            a_q        <= bus.a;
            b_q        <= bus.b;
            idx        <= '0;
            carry_q    <= (bus.op == OP_SUB);
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_nxt[WIDTH-1:1];
          carry_q <= carry_nxt;
          idx     <= idx + IW'(1);
          if (idx == LAST) begin
            y_q         <= res_nxt;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first means no request can be taken on the result-handoff edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign state_dbg     = state;

`ifdef ALU_SERIAL_FLAGS_EN
  logic carry_flag_q;
  logic zero_flag_q;

  // Flags are captured on the same edge as y so they stay aligned with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      carry_flag_q <= carry_nxt;
      zero_flag_q  <= (res_nxt == '0);
    end
  end

  assign bus.carry_out = carry_flag_q;
  assign bus.zero      = zero_flag_q;
`else
  assign bus.carry_out = 1'b0;
  assign bus.zero      = 1'b0;
`endif
endmodule
